// File: rtl/reg_user_seq.sv
// User-sequence register for the memory game: appends key digits into successive
// slots, supports backspace and soft clear, and flags completion against the round length.
module reg_user_seq #(
   parameter  int DIGIT_W = 4,
   parameter  int DEPTH   = 16,
   localparam int CW      = $clog2(DEPTH + 1),
   localparam int SEQ_W   = DIGIT_W * DEPTH
) (
   input  logic               clk,
   input  logic               R,
   input  logic               E,
   input  logic               del,
   input  logic               clr,
   input  logic [DIGIT_W-1:0] digit,
   input  logic [CW-1:0]      len,
   output logic [SEQ_W-1:0]   q,
   output logic [CW-1:0]      count,
   output logic               empty,
   output logic               full,
   output logic               done,
   output logic               ovf
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][DIGIT_W-1:0] r_q;
   logic [CW-1:0]                 r_count;
   logic                          r_ovf;

   logic [DEPTH-1:0][DIGIT_W-1:0] w_q_nxt;
   logic [CW-1:0]                 w_count_nxt;
   logic                          w_ovf_nxt;
   logic [CW-1:0]                 w_last;
   logic [IW-1:0]                 w_wr_idx;
   logic [IW-1:0]                 w_del_idx;
   logic [CW-1:0]                 w_eff_len;
   logic                          w_empty;
   logic                          w_full;

   // Slot indices: next free slot for append, last written slot for backspace.
   assign w_last    = r_count - CW'(1);
   assign w_wr_idx  = r_count[IW-1:0];
   assign w_del_idx = w_last[IW-1:0];

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_eff_len = (len > CW'(DEPTH)) ? CW'(DEPTH) : len;

   // NOTE: every value written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_q_nxt     = r_q;
      w_count_nxt = r_count;
      w_ovf_nxt   = 1'b0;
      if (clr) begin
         w_q_nxt     = '0;
         w_count_nxt = '0;
      end else if (E) begin
         if (w_full) begin
            w_ovf_nxt = 1'b1;
         end else begin
            w_q_nxt[w_wr_idx] = digit;
            w_count_nxt       = r_count + CW'(1);
         end
      end else if (del && !w_empty) begin
         // Vacated slot is zeroed so unused slots always read 0.
         w_q_nxt[w_del_idx] = '0;
         w_count_nxt        = w_last;
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge clk) begin
      if (R) begin
         r_q     <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_q     <= w_q_nxt;
         r_count <= w_count_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign q     = r_q;
   assign count = r_count;
   assign empty = w_empty;
   assign full  = w_full;
   assign done  = (r_count == w_eff_len) && (w_eff_len != '0);
   assign ovf   = r_ovf;

endmodule

// File: doc/reg_user_seq.md
Name: reg_user_seq

Overview:
- Parametrised successor to the 64-bit user-sequence register in the memory-game datapath.
- Builds the player's sequence one digit at a time: each accepted digit goes into the next free slot.
- Tracks how many digits have been entered, supports backspace and soft clear, and flags completion against the current round length.
- Feeds the sequence comparator and the game control FSM.

Parameters:
- DIGIT_W, 4, width of one digit/key code.
- DEPTH, 16, number of digit slots. Total sequence width SEQ_W = DIGIT_W*DEPTH (64 by default).
- CW, $clog2(DEPTH+1), width of count and len. Derived; never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- R  in  1  reset, synchronous, active-high.
- E  in  1  digit strobe: append digit this cycle.
- del  in  1  backspace: remove last entered digit.
- clr  in  1  soft clear of sequence and count, synchronous.
- digit  in  DIGIT_W  key code to append.
- len  in  CW  digits expected this round. Values above DEPTH are treated as DEPTH.
- q  out  SEQ_W  assembled sequence. Slot k is q[k*DIGIT_W +: DIGIT_W] and holds the k-th entered digit (k from 0).
- count  out  CW  number of digits currently stored.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- done  out  1  level: count == eff_len and eff_len != 0, where eff_len = min(len, DEPTH).
- ovf  out  1  one-cycle pulse: E arrived while full.

Behaviour:
- All state changes on the rising edge of clk. Fully synchronous; no combinational path from E/del/clr to q or count.
- Reset (R=1):
  - q=0, count=0, ovf=0 on the next edge.
  - Resulting flags: empty=1, full=0, done=0.
  - R overrides every other input in that cycle.
- Priority per cycle: R > clr > E > del.
- clr=1 (R=0): q=0, count=0, ovf=0. E and del are ignored that cycle.
- Append (E=1, clr=0, count<DEPTH):
  - Slot[count] <= digit; count <= count+1.
  - Other slots unchanged.
  - Latency 1 cycle: q and count show the new digit on the edge after the strobe.
- Append when full (E=1, count==DEPTH):
  - q and count unchanged.
  - ovf=1 for exactly the following cycle.
- Backspace (del=1, E=0, clr=0, count>0):
  - Slot[count-1] <= 0; count <= count-1.
  - Unused slots always read 0.
- Backspace when empty: no effect, no flag.
- E and del in the same cycle: E wins and del is dropped (no net-zero edit).
- ovf is 0 in every cycle not covered above; it is a pulse, not sticky.
- empty, full and done are decoded from registered count and the current len.
  - Changing len mid-entry updates done combinationally.
  - len=0 keeps done=0.
- E held high for N cycles appends N digits, one per cycle, until full. No edge detection here; debouncing and edge detection are upstream.
- Reset asserted mid-entry: all contents are lost in one cycle, and the next E writes slot 0.
- No latches. Every register is assigned in a single clocked process.

Test Plan:
- Reset: R=1 for 2 cycles, with E=1 and digit=4'hF held -> q=0, count=0, empty=1, full=0, done=0, ovf=0.
- Sequential fill: len=4; strobe digits 3,1,2,0 on consecutive cycles -> q[15:0]=16'h0213 with slot0=3, count=4, done=1 on the edge after the 4th strobe, upper bits 0.
- Full/overflow: fill 16 digits 0..F, then E=1 with digit=5 -> q=64'hFEDCBA9876543210 unchanged, count=16, full=1, ovf=1 for one cycle then 0.
- Backspace: after entering 7,9 -> del -> count=1, q=64'h7; del twice more -> count=0, empty=1, second del has no effect; E and del together with digit=2 -> count=1, q=64'h2.
- Priority: count=3; assert clr, E and del together -> q=0, count=0. Then R and E together -> still 0.
- len bounds: len=20 with DEPTH=16 -> done only at count=16. len=0 -> done stays 0 throughout a full fill. Changing len from 5 to 3 at count=3 -> done rises in the same cycle.
